// File: rtl/pcm_codec_if.sv
// rtl/pcm_codec_if.sv - encoder/decoder stream bundle for the pcm_codec block
//
// Signals:
//   enc_in        13  linear sample, sign-magnitude (bit 12 = sign, 11:0 = magnitude)
//   enc_valid      1  enc_in sampled on this clock edge
//   code_out       8  compressed code (bit 7 sign, 6:4 segment, 3:0 mantissa)
//   code_valid     1  code_out holds a new result this cycle
//   dec_in         8  compressed code, same format as code_out
//   dec_valid      1  dec_in sampled on this clock edge
//   dec_out       13  expanded linear sample, same format as enc_in
//   dec_out_valid  1  dec_out holds a new result this cycle
// Modports: slave = codec side, master = sample source/sink side.
interface pcm_codec_if;
  logic [12:0] enc_in;
  logic        enc_valid;
  logic [7:0]  code_out;
  logic        code_valid;
  logic [7:0]  dec_in;
  logic        dec_valid;
  logic [12:0] dec_out;
  logic        dec_out_valid;

  modport slave (
    input  enc_in, enc_valid, dec_in, dec_valid,
    output code_out, code_valid, dec_out, dec_out_valid
  );

  modport master (
    output enc_in, enc_valid, dec_in, dec_valid,
    input  code_out, code_valid, dec_out, dec_out_valid
  );
endinterface

// File: rtl/pcm_codec.sv
// rtl/pcm_codec.sv - 13-segment A-law style PCM compressor/expander
//
// Ports:
//   clk  in   rising-edge clock for all registers
//   rst  in   asynchronous active-low reset (0 = reset asserted)
//   bus  pcm_codec_if.slave: encoder stream (enc_in/enc_valid -> code_out/code_valid)
//        and decoder stream (dec_in/dec_valid -> dec_out/dec_out_valid)
//
// Encoder and decoder are independent one-register pipelines. Results appear
// the cycle after their valid input is sampled; valid strobes last one cycle
// and data registers hold their last value while idle.
//
// Configuration macro: PCM_CODEC_ALT_INVERT_EN
//   defined   - codes on the line are XORed with 8'h55 (even-bit inversion),
//               applied after compression and undone before expansion.
//   undefined - plain codes.
module pcm_codec (
  input logic       clk,
  input logic       rst,
  pcm_codec_if.slave bus
);

`ifdef PCM_CODEC_ALT_INVERT_EN
  localparam logic [7:0] LINE_MASK = 8'h55;
`else
  localparam logic [7:0] LINE_MASK = 8'h00;
`endif

  // Segment is set by the position of the leading one; below 32 the
  // magnitude falls in the linear segment 0, which shares segment 1's step.
  function automatic logic [6:0] compress(input logic [11:0] m);
    logic [6:0] r;
    casez (m)
      12'b1???_????_????: r = {3'd7, m[10:7]};
      12'b01??_????_????: r = {3'd6, m[9:6]};
      12'b001?_????_????: r = {3'd5, m[8:5]};
      12'b0001_????_????: r = {3'd4, m[7:4]};
      12'b0000_1???_????: r = {3'd3, m[6:3]};
      12'b0000_01??_????: r = {3'd2, m[5:2]};
      12'b0000_001?_????: r = {3'd1, m[4:1]};
      default:            r = {3'd0, m[4:1]};
    endcase
    return r;
  endfunction

  // Reconstruct at the midpoint of the quantisation interval:
  // {1, mantissa, 1} equals 33 + 2*mantissa, scaled by the segment step.
  function automatic logic [11:0] expand(input logic [2:0] seg, input logic [3:0] mant);
    logic [11:0] base;
    logic [11:0] r;
    base = {6'd0, 1'b1, mant, 1'b1};
    if (seg == 3'd0) begin
      r = {7'd0, mant, 1'b1};
    end else begin
      r = base << (seg - 3'd1);
    end
    return r;
  endfunction

  logic [7:0]  enc_code;
  logic [7:0]  dec_code;
  logic [12:0] dec_lin;

  always_comb begin
    enc_code = {bus.enc_in[12], compress(bus.enc_in[11:0])} ^ LINE_MASK;
  end

  always_comb begin
    dec_code = bus.dec_in ^ LINE_MASK;
    dec_lin  = {dec_code[7], expand(dec_code[6:4], dec_code[3:0])};
  end

  logic [7:0]  code_q;
  logic        code_valid_q;
  logic [12:0] dec_q;
  logic        dec_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q       <= 8'd0;
      code_valid_q <= 1'b0;
    end else begin
      code_valid_q <= bus.enc_valid;
      if (bus.enc_valid) begin
        code_q <= enc_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q       <= 13'd0;
      dec_valid_q <= 1'b0;
    end else begin
      dec_valid_q <= bus.dec_valid;
      if (bus.dec_valid) begin
        dec_q <= dec_lin;
      end
    end
  end

  assign bus.code_out      = code_q;
  assign bus.code_valid    = code_valid_q;
  assign bus.dec_out       = dec_q;
  assign bus.dec_out_valid = dec_valid_q;

endmodule

// File: tb/tb_pcm_codec.sv
// tb/tb_pcm_codec.sv - self-checking bench for pcm_codec
module tb_pcm_codec;

`ifdef PCM_CODEC_ALT_INVERT_EN
  localparam logic [7:0] ALT = 8'h55;
`else
  localparam logic [7:0] ALT = 8'h00;
`endif

  logic clk;
  logic rst;
  pcm_codec_if bus ();

  logic       loop_mode;
  logic [7:0] dec_in_d;
  logic       dec_valid_d;

  assign bus.dec_in    = loop_mode ? bus.code_out   : dec_in_d;
  assign bus.dec_valid = loop_mode ? bus.code_valid : dec_valid_d;

  pcm_codec dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain code from a linear sample, straight from the segment rules.
  function automatic logic [7:0] ref_enc(input logic [12:0] x);
    int m, p, seg, mant;
    logic [7:0] c;
    m = int'(x[11:0]);
    if (m < 32) begin
      seg  = 0;
      mant = m / 2;
    end else begin
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      seg  = p - 4;
      mant = (m >> seg) % 16;
    end
    c = {x[12], 3'(seg), 4'(mant)};
    return c;
  endfunction

  function automatic logic [12:0] ref_dec(input logic [7:0] c);
    int n, k, mag;
    n = int'(c[6:4]);
    k = int'(c[3:0]);
    if (n == 0) mag = 2 * k + 1;
    else        mag = (33 + 2 * k) * (1 << (n - 1));
    return {c[7], 12'(mag)};
  endfunction

  typedef struct {
    bit          is_dec;
    logic [12:0] din;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0]  exp_code;
    logic [12:0] exp_dec;
    logic [7:0]  prev_code;
    logic [12:0] y;
    int          err, bound;

    vecs[0]  = '{1'b0, 13'd0,    13'h00,   "enc_0"};
    vecs[1]  = '{1'b0, 13'd31,   13'h0F,   "enc_31"};
    vecs[2]  = '{1'b0, 13'd32,   13'h10,   "enc_32"};
    vecs[3]  = '{1'b0, 13'd4095, 13'h7F,   "enc_4095"};
    vecs[4]  = '{1'b0, 13'h1064, 13'hA9,   "enc_neg100"};
    vecs[5]  = '{1'b0, 13'h1000, 13'h80,   "enc_negzero"};
    vecs[6]  = '{1'b1, 13'h00,   13'd1,    "dec_00"};
    vecs[7]  = '{1'b1, 13'h0F,   13'd31,   "dec_0F"};
    vecs[8]  = '{1'b1, 13'h10,   13'd33,   "dec_10"};
    vecs[9]  = '{1'b1, 13'h7F,   13'd4032, "dec_7F"};
    vecs[10] = '{1'b1, 13'hA9,   13'h1066, "dec_A9"};
    vecs[11] = '{1'b1, 13'h80,   13'h1001, "dec_80"};

    checks = 0;
    failures = 0;
    loop_mode = 1'b0;
    bus.enc_in = '0;
    bus.enc_valid = 1'b0;
    dec_in_d = '0;
    dec_valid_d = 1'b0;
    rst = 1'b0;

    #3;
    chk("rst_code_out", 32'(bus.code_out), 32'd0);
    chk("rst_code_valid", 32'(bus.code_valid), 32'd0);
    chk("rst_dec_out", 32'(bus.dec_out), 32'd0);
    chk("rst_dec_out_valid", 32'(bus.dec_out_valid), 32'd0);
    #9 rst = 1'b1;
    step();

    // Directed table: one-cycle strobe, then hold with valid low.
    foreach (vecs[i]) begin
      if (!vecs[i].is_dec) begin
        bus.enc_in = vecs[i].din;
        bus.enc_valid = 1'b1;
        step();
        chk({vecs[i].name, "_code"}, 32'(bus.code_out), 32'(vecs[i].exp[7:0] ^ ALT));
        chk({vecs[i].name, "_valid"}, 32'(bus.code_valid), 32'd1);
        bus.enc_valid = 1'b0;
        bus.enc_in = 13'h1ABC;
        step();
        chk({vecs[i].name, "_drop"}, 32'(bus.code_valid), 32'd0);
        chk({vecs[i].name, "_hold"}, 32'(bus.code_out), 32'(vecs[i].exp[7:0] ^ ALT));
      end else begin
        dec_in_d = vecs[i].din[7:0] ^ ALT;
        dec_valid_d = 1'b1;
        step();
        chk({vecs[i].name, "_lin"}, 32'(bus.dec_out), 32'(vecs[i].exp));
        chk({vecs[i].name, "_valid"}, 32'(bus.dec_out_valid), 32'd1);
        dec_valid_d = 1'b0;
        dec_in_d = 8'h3C;
        step();
        chk({vecs[i].name, "_drop"}, 32'(bus.dec_out_valid), 32'd0);
        chk({vecs[i].name, "_hold"}, 32'(bus.dec_out), 32'(vecs[i].exp));
      end
    end

    // Both paths in the same cycle.
    bus.enc_in = 13'd100;
    bus.enc_valid = 1'b1;
    dec_in_d = 8'hA9 ^ ALT;
    dec_valid_d = 1'b1;
    step();
    chk("both_code", 32'(bus.code_out), 32'(8'h29 ^ ALT));
    chk("both_dec", 32'(bus.dec_out), 32'h1066);
    chk("both_valids", 32'({bus.code_valid, bus.dec_out_valid}), 32'd3);
    bus.enc_valid = 1'b0;
    dec_valid_d = 1'b0;

    // Random independent traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic ev, dv;
      logic [12:0] x;
      logic [7:0] c;
      ev = (i == 0) ? 1'b1 : 1'($urandom % 2);
      dv = (i == 0) ? 1'b1 : 1'($urandom % 2);
      x  = 13'($urandom % 8192);
      c  = 8'($urandom % 256);
      bus.enc_in = x;
      bus.enc_valid = ev;
      dec_in_d = c;
      dec_valid_d = dv;
      if (ev) exp_code = ref_enc(x) ^ ALT;
      if (dv) exp_dec = ref_dec(c ^ ALT);
      step();
      chk("rnd_code_valid", 32'(bus.code_valid), 32'(ev));
      chk("rnd_code", 32'(bus.code_out), 32'(exp_code));
      chk("rnd_dec_valid", 32'(bus.dec_out_valid), 32'(dv));
      chk("rnd_dec", 32'(bus.dec_out), 32'(exp_dec));
      checks++;
      if (bus.dec_out[11:0] > 12'd4032) begin
        failures++;
        $display("FAIL rnd_dec_max actual=%0d expected<=4032", bus.dec_out[11:0]);
      end
    end
    bus.enc_valid = 1'b0;
    dec_valid_d = 1'b0;
    step();

    // Counter sweep with the encoder output looped into the decoder.
    loop_mode = 1'b1;
    prev_code = '0;
    for (int i = 0; i <= 8193; i++) begin
      bus.enc_in = 13'(i);
      bus.enc_valid = (i < 8192);
      step();
      if (i < 8192) begin
        chk("sweep_code", 32'(bus.code_out), 32'(ref_enc(13'(i)) ^ ALT));
        chk("sweep_code_valid", 32'(bus.code_valid), 32'd1);
        if ((i % 4096) != 0) begin
          checks++;
          if (((bus.code_out ^ ALT) & 8'h7F) < (prev_code & 8'h7F)) begin
            failures++;
            $display("FAIL sweep_monotonic at %0d actual=%0h previous=%0h", i, bus.code_out ^ ALT, prev_code);
          end
        end
        prev_code = bus.code_out ^ ALT;
      end
      if (i >= 1 && i <= 8192) begin
        y = 13'(i - 1);
        chk("sweep_dec_valid", 32'(bus.dec_out_valid), 32'd1);
        chk("sweep_sign", 32'(bus.dec_out[12]), 32'(y[12]));
        err = int'(bus.dec_out[11:0]) - int'(y[11:0]);
        if (err < 0) err = -err;
        bound = (y[11:0] < 12'd32) ? 1 : (1 << (int'(ref_enc(y) >> 4 & 8'h7) - 1));
        checks++;
        if (err > bound) begin
          failures++;
          $display("FAIL sweep_err at %0d actual=%0d expected<=%0d", i - 1, err, bound);
        end
      end
    end
    chk("sweep_end_valid", 32'({bus.code_valid, bus.dec_out_valid}), 32'd0);

    // Reset between edges in the middle of a looped stream.
    for (int i = 0; i < 5; i++) begin
      bus.enc_in = 13'(1000 + i * 37);
      bus.enc_valid = 1'b1;
      step();
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_code_out", 32'(bus.code_out), 32'd0);
    chk("midrst_code_valid", 32'(bus.code_valid), 32'd0);
    chk("midrst_dec_out", 32'(bus.dec_out), 32'd0);
    chk("midrst_dec_out_valid", 32'(bus.dec_out_valid), 32'd0);
    step();
    chk("midrst_held", 32'({bus.code_out, bus.code_valid, bus.dec_out, bus.dec_out_valid}), 32'd0);
    rst = 1'b1;
    y = 13'h1ABC;
    bus.enc_in = y;
    step();
    chk("postrst_code", 32'(bus.code_out), 32'(ref_enc(y) ^ ALT));
    chk("postrst_code_valid", 32'(bus.code_valid), 32'd1);
    chk("postrst_dec_valid", 32'(bus.dec_out_valid), 32'd0);
    bus.enc_valid = 1'b0;
    step();
    chk("postrst_dec", 32'(bus.dec_out), 32'(ref_dec(ref_enc(y))));
    chk("postrst_dec_valid2", 32'(bus.dec_out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
